// File: rtl/acc_ram_rmw.sv
// acc_ram_rmw
//   Single-port accumulator RAM built from NUM_BANKS byte-wide synchronous
//   arrays (DATA_W = 8*NUM_BANKS bits per word, DEPTH words). It supports
//   READ, byte-strobed WRITE, read-modify-write ACC with optional signed
//   saturation, and a self-timed CLEAR sweep that zeroes every word.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  request accepted on req_valid_i & req_ready_o
//   req_op_i     00 READ, 01 WRITE, 10 ACC, 11 CLEAR
//   req_addr_i   word address (ignored for CLEAR)
//   req_wdata_i  write data / signed ACC addend
//   req_be_i     byte strobes, used by WRITE only
//   rsp_valid_o  one-cycle response pulse (READ and ACC)
//   rsp_data_o   READ: stored word, ACC: written-back sum
//   clr_done_o   one-cycle pulse on the final CLEAR write
//   sat_o        one-cycle pulse alongside an ACC response that was clipped
//   dbg_state_o  current FSM state (00 IDLE, 01 ACC_WB, 10 CLEAR)
//
// Handshake: a request is taken on any rising edge where req_valid_i and
// req_ready_o are both high; fields are sampled only then, and the requester
// holds them stable while req_ready_o is low. Responses have no backpressure
// and each accepted READ or ACC produces exactly one rsp_valid_o pulse.
module acc_ram_rmw #(
  parameter int NUM_BANKS = 4,
  parameter int DEPTH     = 2048,
  parameter int SAT       = 1,
  localparam int DATA_W   = 8 * NUM_BANKS,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_op_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [DATA_W-1:0]    req_wdata_i,
  input  logic [NUM_BANKS-1:0] req_be_i,
  output logic                 rsp_valid_o,
  output logic [DATA_W-1:0]    rsp_data_o,
  output logic                 clr_done_o,
  output logic                 sat_o,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACC_WB = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ACC   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]           state;
  logic [ADDR_W-1:0]    cnt;
  logic [ADDR_W-1:0]    acc_addr;
  logic [DATA_W-1:0]    addend;
  logic                 acc_in_range;
  logic                 rd_pend;
  logic                 rd_in_range;

  logic                 accept;
  logic                 req_in_range;

  logic [ADDR_W-1:0]    mem_addr;
  logic [NUM_BANKS-1:0] mem_we;
  logic                 mem_re;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_q;

  logic [DATA_W-1:0]    acc_q;
  logic [DATA_W:0]      sum_wide;
  logic                 ovf;
  logic                 acc_sat;
  logic [DATA_W-1:0]    acc_sum;

  assign accept       = req_valid_i && (state == S_IDLE);
  // Only matters when DEPTH is not a power of two.
  assign req_in_range = ({1'b0, req_addr_i} < DEPTH_W);

  // Single shared port: address, strobes and write data all come from the
  // one place that owns the array in the current state.
  always_comb begin
    mem_addr  = req_addr_i;
    mem_we    = '0;
    mem_re    = 1'b0;
    mem_wdata = req_wdata_i;
    case (state)
      S_IDLE: begin
        if (accept && (req_op_i == OP_WRITE) && req_in_range) mem_we = req_be_i;
        if (accept && ((req_op_i == OP_READ) || (req_op_i == OP_ACC))) mem_re = 1'b1;
      end
      S_ACC_WB: begin
        mem_addr  = acc_addr;
        mem_wdata = acc_sum;
        if (acc_in_range) mem_we = '1;
      end
      S_CLEAR: begin
        mem_addr  = cnt;
        mem_wdata = '0;
        mem_we    = '1;
      end
      default: begin
        mem_we = '0;
      end
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] q_b;

    always_ff @(posedge clk) begin
      if (mem_we[b]) mem[mem_addr] <= mem_wdata[8*b +: 8];
      if (mem_re)    q_b           <= mem[mem_addr];
    end

    assign mem_q[8*b +: 8] = q_b;
  end

  // Signed add one bit wider than the word; overflow shows up as the top
  // two bits disagreeing. An out-of-range ACC accumulates onto zero.
  assign acc_q    = acc_in_range ? mem_q : '0;
  assign sum_wide = {acc_q[DATA_W-1], acc_q} + {addend[DATA_W-1], addend};
  assign ovf      = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
  assign acc_sat  = (SAT != 0) && ovf;

  always_comb begin
    acc_sum = sum_wide[DATA_W-1:0];
    if (acc_sat) begin
      acc_sum = sum_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      acc_addr     <= '0;
      addend       <= '0;
      acc_in_range <= 1'b0;
      rd_pend      <= 1'b0;
      rd_in_range  <= 1'b0;
    end else begin
      rd_pend     <= accept && (req_op_i == OP_READ);
      rd_in_range <= req_in_range;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (req_op_i)
              OP_ACC: begin
                acc_addr     <= req_addr_i;
                addend       <= req_wdata_i;
                acc_in_range <= req_in_range;
                state        <= S_ACC_WB;
              end
              OP_CLEAR: begin
                cnt   <= '0;
                state <= S_CLEAR;
              end
              default: begin
                state <= S_IDLE;
              end
            endcase
          end
        end
        S_ACC_WB: begin
          state <= S_IDLE;
        end
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state == S_IDLE);
  assign rsp_valid_o = rd_pend || (state == S_ACC_WB);
  assign rsp_data_o  = (state == S_ACC_WB)         ? acc_sum :
                       (rd_pend && rd_in_range)     ? mem_q   : '0;
  assign sat_o       = (state == S_ACC_WB) && acc_sat;
  assign clr_done_o  = (state == S_CLEAR) && (cnt == LAST_ADDR);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_acc_ram_rmw.sv
// tb_acc_ram_rmw
//   Bench for acc_ram_rmw with NUM_BANKS=4, DEPTH=12 (non-power-of-two so
//   out-of-range addresses exist), SAT=1. Expected responses are pushed to
//   exp_q when a request is driven and compared when rsp_valid_o fires.
module tb_acc_ram_rmw;

  localparam int NUM_BANKS = 4;
  localparam int DEPTH     = 12;
  localparam int SAT       = 1;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ACC   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [ADDR_W-1:0]    req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic [NUM_BANKS-1:0] req_be;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_data;
  logic                 clr_done;
  logic                 sat;
  logic [1:0]           dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] model [DEPTH];

  acc_ram_rmw #(
    .NUM_BANKS(NUM_BANKS),
    .DEPTH    (DEPTH),
    .SAT      (SAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_op_i   (req_op),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_be_i   (req_be),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .clr_done_o (clr_done),
    .sat_o      (sat),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: compares every response against the head of exp_q
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got data=%h sat=%0b", rsp_data, sat);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        if ({sat, rsp_data} !== e)
          begin
            failures++;
            $display("FAIL rsp_data got data=%h sat=%0b want data=%h sat=%0b",
                     rsp_data, sat, e[DATA_W-1:0], e[DATA_W]);
          end
      end
    end
    if (rst && sat && !rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL sat_without_rsp got sat=1 want 0");
    end
  end

  // driver: present a request, wait (bounded) for acceptance, return #1
  // after the accepting edge
  task automatic drive(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [NUM_BANKS-1:0] be);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout got ready=0 want ready=1 within 200 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [NUM_BANKS-1:0] be);
    if (a < DEPTH) begin
      for (int i = 0; i < NUM_BANKS; i++)
        if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    drive(OP_WRITE, ADDR_W'(a), d, be);
  endtask

  task automatic rd(input int a);
    exp_q.push_back({1'b0, (a < DEPTH) ? model[a] : 32'h0});
    drive(OP_READ, ADDR_W'(a), '0, '0);
  endtask

  task automatic acc(input int a, input logic [DATA_W-1:0] d);
    longint s;
    logic [DATA_W-1:0] r;
    logic clip;
    s = longint'($signed(model[a])) + longint'($signed(d));
    clip = 1'b0;
    if (s > MAXV) begin
      r = 32'h7FFF_FFFF; clip = 1'b1;
    end else if (s < MINV) begin
      r = 32'h8000_0000; clip = 1'b1;
    end else begin
      r = s[31:0];
    end
    model[a] = r;
    exp_q.push_back({clip, r});
    drive(OP_ACC, ADDR_W'(a), d, '0);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || clr_done !== 1'b0 ||
        sat !== 1'b0 || rsp_data !== '0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL %s got ready=%b rsp_valid=%b clr_done=%b sat=%b data=%h state=%0d want 1 0 0 0 0 0",
               tag, req_ready, rsp_valid, clr_done, sat, rsp_data, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_READ;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_write_read();
    wr(5, 32'h1122_3344, 4'b1111);
    rd(5);
    wr(5, 32'hAABB_CCDD, 4'b0101);
    rd(5);
    wr(5, 32'hFFFF_FFFF, 4'b0000);
    rd(5);
    for (int a = 0; a < DEPTH; a++) if (a != 5) wr(a, $urandom, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      wr(a, $urandom, 4'($urandom_range(0, 15)));
      rd(a);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_write_read got %b want 1", req_ready);
    end
  endtask

  task automatic test_back_to_back_acc();
    wr(9, 32'd10, 4'b1111);
    acc(9, 32'd7);
    checks++;
    if (req_ready !== 1'b0 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL acc1_ready_gap got ready=%b state=%0d want ready=0 state=1", req_ready, dbg_state);
    end
    acc(9, -32'sd20);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL acc2_ready_gap got ready=%b want 0", req_ready);
    end
    rd(9);
  endtask

  task automatic test_saturation();
    wr(2, 32'h7FFF_FFF0, 4'b1111);
    acc(2, 32'h0000_0100);
    rd(2);
    wr(3, 32'h8000_0010, 4'b1111);
    acc(3, 32'hFFFF_FF00);
    acc(3, 32'd5);
    rd(3);
    acc(7, $urandom);
    acc(7, $urandom);
  endtask

  task automatic test_out_of_range();
    int keep;
    keep = 13 - 8;
    wr(13, 32'hDEAD_BEEF, 4'b1111);
    rd(13);
    wr(15, 32'hCAFE_F00D, 4'b1111);
    rd(15);
    rd(keep);
    rd(DEPTH - 1);
  endtask

  task automatic test_clear();
    int busy;
    int done_at;
    int pulses;
    busy = 0; done_at = -1; pulses = 0;
    drive(OP_CLEAR, 4'd3, '0, '0);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    // READ held across the sweep; accepted on the first ready cycle
    exp_q.push_back({1'b0, 32'h0});
    req_valid = 1'b1;
    req_op    = OP_READ;
    req_addr  = 4'd5;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      @(negedge clk);
      if (!req_ready) busy++;
      if (clr_done) begin
        done_at = c;
        pulses++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (busy !== DEPTH) begin
      failures++;
      $display("FAIL clear_busy_cycles got %0d want %0d", busy, DEPTH);
    end
    checks++;
    if (done_at !== DEPTH) begin
      failures++;
      $display("FAIL clear_done_cycle got %0d want %0d", done_at, DEPTH);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL clear_done_pulses got %0d want 1", pulses);
    end
    for (int a = 0; a < DEPTH; a++) rd(a);
  endtask

  task automatic test_reset_mid();
    // abort an ACC writeback
    wr(4, 32'h1234_5678, 4'b1111);
    drive(OP_ACC, 4'd4, 32'd1, '0);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_in_acc_wb");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd(4);

    // abort a CLEAR sweep after five words
    for (int a = 0; a < DEPTH; a++) wr(a, 32'h0000_0100 + a, 4'b1111);
    drive(OP_CLEAR, '0, '0, '0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("reset_in_clear");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 5; a++) model[a] = '0;
    for (int a = 0; a < DEPTH; a++) rd(a);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back_acc();
    test_saturation();
    test_out_of_range();
    test_clear();
    test_reset_mid();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rsp_missing got %0d outstanding want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
